// File: rtl/msg_block_packer_pkg.sv
// msg_block_packer_pkg: shared block geometry constants and packer FSM states
package msg_block_packer_pkg;
  localparam int WORD_W = 64;
  localparam int BLK_W = 512;
  localparam int WORDS_PER_BLK = 8;
  typedef enum logic {FILL, FULL} state_t;
endpackage

// File: rtl/msg_block_packer_if.sv
// msg_block_packer_if: word input stream, block output and block acknowledge
interface msg_block_packer_if;
  import msg_block_packer_pkg::*;
  logic [WORD_W-1:0] w_data;
  logic w_valid;
  logic w_last;
  logic [2:0] w_bytes;
  logic w_ready;
  logic [BLK_W-1:0] msg;
  logic [2:0] bytenum;
  logic [3:0] words;
  logic msg_last;
  logic in_ready;
  logic blk_ack;
  modport master (
    output w_data, w_valid, w_last, w_bytes, blk_ack,
    input w_ready, msg, bytenum, words, msg_last, in_ready
  );
  modport slave (
    input w_data, w_valid, w_last, w_bytes, blk_ack,
    output w_ready, msg, bytenum, words, msg_last, in_ready
  );
endinterface

// File: rtl/msg_block_packer_byte_mask_gen.sv
// byte_mask_gen: keep mask for a word, upper n bytes kept on a partial final word
module byte_mask_gen
  import msg_block_packer_pkg::*;
(
  input  logic last,
  input  logic [2:0] bytes,
  output logic [WORD_W-1:0] mask
);
  assign mask = (last && bytes != 3'd0) ? ~({WORD_W{1'b1}} >> {bytes, 3'b000}) : {WORD_W{1'b1}};
endmodule

// File: rtl/msg_block_packer.sv
// msg_block_packer: packs 64-bit message words MSB-first into 512-bit blocks
module msg_block_packer
  import msg_block_packer_pkg::*;
(
  input logic clk,
  input logic rst_n,
  msg_block_packer_if.slave bus
);
  state_t state;
  logic [2:0] idx;
  logic [BLK_W-1:0] msg_q;
  logic [BLK_W-1:0] msg_nxt;
  logic [2:0] bytenum_q;
  logic [3:0] words_q;
  logic last_q;
  logic [WORD_W-1:0] mask;
  byte_mask_gen u_mask (.last(bus.w_last), .bytes(bus.w_bytes), .mask(mask));
  // first word of a block starts from a clean slate so no stale slots survive
  always_comb begin
    msg_nxt = (idx == 3'd0) ? '0 : msg_q;
    msg_nxt[{~idx, 6'b000000} +: WORD_W] = bus.w_data & mask;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
      idx <= '0;
      msg_q <= '0;
      bytenum_q <= '0;
      words_q <= '0;
      last_q <= 1'b0;
    end else if (state == FILL && bus.w_valid) begin
      msg_q <= msg_nxt;
      idx <= idx + 3'd1;
      if (bus.w_last || idx == 3'd7) begin
        state <= FULL;
        words_q <= {1'b0, idx} + 4'd1;
        bytenum_q <= bus.w_last ? bus.w_bytes : 3'd0;
        last_q <= bus.w_last;
      end
    end else if (state == FULL && bus.blk_ack) begin
      state <= FILL;
      idx <= '0;
    end
  end
  assign bus.w_ready = state == FILL;
  assign bus.in_ready = state == FULL;
  assign bus.msg = msg_q;
  assign bus.bytenum = bytenum_q;
  assign bus.words = words_q;
  assign bus.msg_last = last_q;
endmodule
